// File: rtl/write_resp_router_pkg.sv
// rtl/write_resp_router_pkg.sv - shared AXI interconnect types for the write response router
package write_resp_router_pkg;

    typedef enum logic [1:0] {
        BRESP_OKAY   = 2'b00,
        BRESP_EXOKAY = 2'b01,
        BRESP_SLVERR = 2'b10,
        BRESP_DECERR = 2'b11
    } bresp_e;

    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = '1;

endpackage

// File: rtl/write_resp_router_resp_skid_fifo.sv
// rtl/write_resp_router_resp_skid_fifo.sv - 2-entry in-order buffer with registered ready
//
// Ports:
//   clk, rst_n                    clock, asynchronous active-low reset
//   s_tdata/s_tvalid/s_tready     write side; s_tready depends on registered state only
//   m_tdata/m_tvalid/m_tready     read side; m_tdata is the oldest entry
module resp_skid_fifo #(
    parameter int DW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    output logic          s_tready,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    input  logic          m_tready
);

    logic [DW-1:0] head_q;
    logic [DW-1:0] tail_q;
    logic [1:0]    count_q;
    // Holds s_tready low while in reset and releases it on the first edge afterwards.
    logic          live_q;
    logic          push;
    logic          pop;

    assign s_tready = live_q && (count_q != 2'd2);
    assign m_tvalid = (count_q != 2'd0);
    assign m_tdata  = head_q;
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
            live_q  <= 1'b0;
        end else begin
            live_q <= 1'b1;
            case ({push, pop})
                // Push is never accepted when full, so push+pop means one entry
                // leaves and the incoming one becomes the new head.
                2'b11: head_q <= s_tdata;
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= s_tdata;
                    end else begin
                        tail_q <= s_tdata;
                    end
                    count_q <= count_q + 2'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/write_resp_router.sv
// rtl/write_resp_router.sv - routes slave write responses to the master owning the ID
//
// Ports:
//   ACLK, ARESETN               clock, asynchronous active-low reset
//   s_bid/s_bresp/s_bvalid      slave-side response; s_bready accepts it
//   m_bresp/m_bvalid/m_bready   per-master response, master i on bits [2i+1:2i]
//   err_clr                     one-cycle clear of the drop status
//   err_sticky, drop_cnt        unmapped-ID drop flag and saturating drop count
module write_resp_router
    import write_resp_router_pkg::*;
#(
    parameter int NUM_MASTERS = 3,
    parameter int ID_WIDTH    = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESETN,
    input  logic [ID_WIDTH-1:0]      s_bid,
    input  logic [1:0]               s_bresp,
    input  logic                     s_bvalid,
    output logic                     s_bready,
    output logic [2*NUM_MASTERS-1:0] m_bresp,
    output logic [NUM_MASTERS-1:0]   m_bvalid,
    input  logic [NUM_MASTERS-1:0]   m_bready,
    input  logic                     err_clr,
    output logic                     err_sticky,
    output logic [DROP_CNT_W-1:0]    drop_cnt
);

    localparam int DW = ID_WIDTH + 2;

    logic                mapped;
    logic                drop;
    logic [DW-1:0]       head_data;
    logic                head_valid;
    logic [ID_WIDTH-1:0] head_id;
    logic [1:0]          head_resp;

    assign mapped = (32'(s_bid) < 32'(NUM_MASTERS));
    assign drop   = s_bvalid && s_bready && !mapped;

    // Unmapped responses see the same ready but never enter the buffer.
    resp_skid_fifo #(.DW(DW)) u_fifo (
        .clk      (ACLK),
        .rst_n    (ARESETN),
        .s_tdata  ({s_bid, s_bresp}),
        .s_tvalid (s_bvalid && mapped),
        .s_tready (s_bready),
        .m_tdata  (head_data),
        .m_tvalid (head_valid),
        .m_tready (|(m_bvalid & m_bready))
    );

    assign head_id   = head_data[DW-1:2];
    assign head_resp = head_data[1:0];
    assign m_bresp   = {NUM_MASTERS{head_resp}};

    always_comb begin
        m_bvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            m_bvalid[i] = head_valid && (head_id == ID_WIDTH'(i));
        end
    end

    // A clear that coincides with a drop counts that drop as the first one.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            err_sticky <= 1'b0;
            drop_cnt   <= '0;
        end else if (err_clr) begin
            err_sticky <= drop;
            drop_cnt   <= drop ? DROP_CNT_W'(1) : '0;
        end else if (drop) begin
            err_sticky <= 1'b1;
            if (drop_cnt != DROP_CNT_MAX) begin
                drop_cnt <= drop_cnt + DROP_CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_write_resp_router.sv
// tb/tb_write_resp_router.sv - scoreboard bench for write_resp_router
module tb_write_resp_router;

    localparam int NM = 3;

    logic       ACLK = 1'b0;
    logic       ARESETN = 1'b0;
    logic [1:0] s_bid = '0;
    logic [1:0] s_bresp = '0;
    logic       s_bvalid = 1'b0;
    logic       s_bready;
    logic [5:0] m_bresp;
    logic [2:0] m_bvalid;
    logic [2:0] m_bready = '0;
    logic       err_clr = 1'b0;
    logic       err_sticky;
    logic [7:0] drop_cnt;

    write_resp_router #(.NUM_MASTERS(NM)) dut (
        .ACLK       (ACLK),
        .ARESETN    (ARESETN),
        .s_bid      (s_bid),
        .s_bresp    (s_bresp),
        .s_bvalid   (s_bvalid),
        .s_bready   (s_bready),
        .m_bresp    (m_bresp),
        .m_bvalid   (m_bvalid),
        .m_bready   (m_bready),
        .err_clr    (err_clr),
        .err_sticky (err_sticky),
        .drop_cnt   (drop_cnt)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic [1:0] id;
        logic [1:0] resp;
    } ent_t;

    ent_t exp_q[$];
    int   delivered[$];
    int   total = 0;
    int   bad = 0;
    bit   live = 0;
    bit   m_sticky = 0;
    int   m_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    // Ready is only expected once a rising edge has been seen out of reset.
    always @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) live = 0;
        else live = 1;
    end

    // Monitor: compare what the DUT presents against the model, then advance
    // the model with the handshakes that the next rising edge will complete.
    always @(negedge ACLK) begin
        bit   exp_ready;
        bit   drop;
        logic [2:0] exp_v;
        if (!ARESETN) begin
            exp_q.delete();
            m_sticky = 0;
            m_cnt = 0;
            chk("rst_s_bready", s_bready, 0);
            chk("rst_m_bvalid", m_bvalid, 0);
            chk("rst_m_bresp", m_bresp, 0);
            chk("rst_err_sticky", err_sticky, 0);
            chk("rst_drop_cnt", drop_cnt, 0);
        end else begin
            exp_ready = live && (exp_q.size() < 2);
            chk("s_bready", s_bready, exp_ready);
            exp_v = (exp_q.size() > 0) ? (3'b001 << exp_q[0].id) : 3'b000;
            chk("m_bvalid", m_bvalid, exp_v);
            if (exp_q.size() > 0)
                chk("m_bresp", m_bresp[2*exp_q[0].id +: 2], exp_q[0].resp);
            chk("err_sticky", err_sticky, m_sticky);
            chk("drop_cnt", drop_cnt, m_cnt);

            if (exp_q.size() > 0 && m_bready[exp_q[0].id]) begin
                delivered.push_back(int'(exp_q[0].id));
                void'(exp_q.pop_front());
            end
            drop = 0;
            if (s_bvalid && exp_ready) begin
                if (s_bid < NM) exp_q.push_back('{id: s_bid, resp: s_bresp});
                else drop = 1;
            end
            if (err_clr) begin
                m_sticky = drop;
                m_cnt = drop ? 1 : 0;
            end else if (drop) begin
                m_sticky = 1;
                m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic send(input logic [1:0] id, input logic [1:0] resp);
        bit ok = 0;
        s_bid = id;
        s_bresp = resp;
        s_bvalid = 1'b1;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge ACLK);
            ok = s_bready;
            @(posedge ACLK);
            #1;
        end
        s_bvalid = 1'b0;
        if (!ok) begin
            bad++;
            total++;
            $display("FAIL send_timeout actual=0 required=1 t=%0t", $time);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge ACLK);
            #1;
        end
    endtask

    initial begin
        idle(3);
        ARESETN = 1'b1;
        idle(1);

        // Single response to master 1, all masters ready.
        m_bready = 3'b111;
        send(2'd1, 2'b10);
        @(negedge ACLK);
        chk("first_m_bvalid", m_bvalid, 3'b010);
        chk("first_m_bresp", m_bresp[3:2], 2'b10);
        @(posedge ACLK); #1;
        idle(2);

        // Back-to-back 0,2,1 with masters stalled.
        m_bready = 3'b000;
        delivered.delete();
        send(2'd0, 2'b00);
        send(2'd2, 2'b01);
        s_bid = 2'd1; s_bresp = 2'b11; s_bvalid = 1'b1;
        idle(4);
        // Master 2 ready but master 0 at the head: nothing may bypass.
        m_bready = 3'b100;
        idle(4);
        m_bready = 3'b111;
        send(2'd1, 2'b11);
        idle(4);
        chk("order_len", delivered.size(), 3);
        if (delivered.size() == 3) begin
            chk("order_0", delivered[0], 0);
            chk("order_1", delivered[1], 2);
            chk("order_2", delivered[2], 1);
        end

        // Unmapped ID: one, then saturation.
        send(2'd3, 2'b00);
        @(negedge ACLK);
        chk("unmapped_no_valid", m_bvalid, 0);
        chk("unmapped_sticky", err_sticky, 1);
        chk("unmapped_cnt", drop_cnt, 1);
        @(posedge ACLK); #1;
        for (int i = 0; i < 299; i++) send(2'd3, 2'($urandom_range(0, 3)));
        @(negedge ACLK);
        chk("sat_cnt", drop_cnt, 255);
        @(posedge ACLK); #1;

        // Clear coinciding with an unmapped response.
        err_clr = 1'b1;
        send(2'd3, 2'b01);
        err_clr = 1'b0;
        @(negedge ACLK);
        chk("clr_drop_sticky", err_sticky, 1);
        chk("clr_drop_cnt", drop_cnt, 1);
        @(posedge ACLK); #1;

        // Randomised traffic.
        for (int c = 0; c < 600; c++) begin
            s_bvalid = ($urandom_range(0, 3) != 0);
            s_bid    = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            s_bresp  = 2'($urandom_range(0, 3));
            m_bready = 3'($urandom_range(0, 7));
            err_clr  = ($urandom_range(0, 40) == 0);
            idle(1);
        end
        s_bvalid = 1'b0;
        err_clr = 1'b0;
        m_bready = 3'b111;
        idle(4);

        // Reset with two entries buffered.
        m_bready = 3'b000;
        send(2'd2, 2'b10);
        send(2'd0, 2'b01);
        idle(1);
        #2;
        ARESETN = 1'b0;
        #1;
        chk("async_rst_m_bvalid", m_bvalid, 0);
        chk("async_rst_s_bready", s_bready, 0);
        idle(2);
        ARESETN = 1'b1;
        m_bready = 3'b111;
        idle(3);
        chk("post_rst_empty", m_bvalid, 0);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/write_resp_router.md
WRITE_RESP_ROUTER -- requirements
Module: write_resp_router

Interface
REQ-001 The block SHALL take parameter NUM_MASTERS, default 3, as the number of master-side response ports (legal range 2..16).
REQ-002 The block SHALL take parameter ID_WIDTH, default max(1,$clog2(NUM_MASTERS)), as the width of the response ID.
REQ-003 Port ACLK, input, 1: the single clock; all logic is on its rising edge.
REQ-004 Port ARESETN, input, 1: reset, asynchronous assert, active-low.
REQ-005 Port s_bid, input, ID_WIDTH: ID of the response presented by the slave side.
REQ-006 Port s_bresp, input, 2: write response code from the slave side.
REQ-007 Port s_bvalid, input, 1: slave-side response valid.
REQ-008 Port s_bready, output, 1: slave-side response accepted.
REQ-009 Port m_bresp, output, 2*NUM_MASTERS: flattened per-master response code; master i uses bits [2i+1:2i].
REQ-010 Port m_bvalid, output, NUM_MASTERS: per-master response valid.
REQ-011 Port m_bready, input, NUM_MASTERS: per-master response ready.
REQ-012 Port err_clr, input, 1: single-cycle clear of error status.
REQ-013 Port err_sticky, output, 1: set when a response with an unmapped ID has been dropped.
REQ-014 Port drop_cnt, output, 8: saturating count of dropped responses.

Function
REQ-015 Master i SHALL own ID value i; an ID >= NUM_MASTERS SHALL be unmapped.
REQ-016 A slave-side transfer SHALL occur on a cycle where s_bvalid and s_bready are both 1.
REQ-017 Mapped transfers SHALL be written into a 2-entry in-order buffer holding {id, bresp}.
REQ-018 s_bready SHALL be 1 exactly when the buffer holds fewer than 2 entries, computed from registered occupancy only (no combinational path from m_bready).
REQ-019 An unmapped transfer SHALL be accepted under the same s_bready rule, SHALL NOT be stored, and SHALL NOT produce any m_bvalid.
REQ-020 Buffer head with id k SHALL drive m_bvalid[k]=1; all other m_bvalid bits SHALL be 0; all m_bvalid SHALL be 0 when the buffer is empty.
REQ-021 Every m_bresp slice SHALL carry the head bresp unchanged; it is a don't-care when the matching m_bvalid is 0.
REQ-022 The head SHALL pop on a cycle where m_bvalid[k] and m_bready[k] are both 1.
REQ-023 Latency: a response accepted in cycle t into an empty buffer SHALL appear on m_bvalid in cycle t+1.
REQ-024 Simultaneous push and pop with one entry SHALL keep occupancy at 1 with the new entry as head in the next cycle.
REQ-025 A response SHALL be delivered in acceptance order; a stalled head SHALL block later responses to other masters (no reordering).
REQ-026 Once asserted, m_bvalid[k] and its bresp SHALL hold stable until popped.
REQ-027 An unmapped transfer SHALL set err_sticky and increment drop_cnt, saturating at 255, in the following cycle.
REQ-028 err_clr SHALL clear err_sticky and drop_cnt to 0; if it coincides with an unmapped transfer, the result SHALL be err_sticky=1 and drop_cnt=1.

Reset
REQ-029 While ARESETN=0, the buffer SHALL be empty, s_bready=0, m_bvalid=0, m_bresp=0, err_sticky=0 and drop_cnt=0.
REQ-030 s_bready SHALL rise in the first ACLK cycle after ARESETN deasserts.
REQ-031 Reset asserted mid-transfer SHALL discard all buffered responses with no partial delivery.

Structure
REQ-032 BRESP encodings (OKAY=00, EXOKAY=01, SLVERR=10, DECERR=11) and the drop-counter width SHALL be placed in the shared AXI interconnect package.
REQ-033 The 2-entry buffer SHALL be a sub-module named resp_skid_fifo, parametrised by data width.

Verification
REQ-034 Reset release, then s_bid=1, s_bresp=10 pulse with m_bready=all 1 -> m_bvalid=010 one cycle later, m_bresp[3:2]=10, and the entry popped in that cycle.
REQ-035 m_bready=0 and three back-to-back mapped responses (IDs 0,2,1) -> s_bready=0 after two accepts; after m_bready is released, delivery order is 0,2,1.
REQ-036 Head for master 0 stalled with a queued response for master 2 -> m_bvalid[2] stays 0 until master 0 pops.
REQ-037 s_bid=3 with NUM_MASTERS=3 -> accepted, no m_bvalid, err_sticky=1, drop_cnt=1; 300 such responses -> drop_cnt=255.
REQ-038 err_clr coinciding with an unmapped response -> err_sticky=1, drop_cnt=1 next cycle.
REQ-039 ARESETN pulsed low with 2 entries buffered -> m_bvalid=0 immediately and the buffer empty after release.
